flash_spi_rd_seq: RTL and testbench
===================================

# flash_spi_rd_seq

Read sequencer that sits directly upstream of the flash SPI master (8-bit, mode 0, one slave) and drives its register port. It accepts a (byte address, length) read command, issues the flash READ opcode plus 24-bit address, and clocks out dummy bytes. It returns each received byte on a valid/ready stream. Slave select is held across the whole transaction through the master's SSO control bit.

## Interface
Parameters:
- `OPCODE_READ`, default 8'h03: normal-read opcode.
- `OPCODE_FAST`, default 8'h0B: fast-read opcode, used only with the macro.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, same as the SPI master.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_addr` in 24: flash byte address.
- `cmd_len` in 16: data bytes to return; 0 means header only.
- `rd_data` out 8: received byte.
- `rd_valid` out 1: `rd_data` is valid.
- `rd_ready` in 1: consumer accepts the byte.
- `busy` out 1: high when state is not IDLE.
- `done` out 1: one-cycle pulse when the transaction ends.
- `spi_select` out 1: SPI master chip select.
- `mem_addr` out 3: SPI master register address.
- `write_n` out 1: SPI master write strobe, active low.
- `read_n` out 1: SPI master read strobe, active low.
- `data_from_cpu` out 16: write data to the SPI master.
- `data_to_cpu` in 16: read data from the SPI master.
- `dataavailable` in 1: SPI master RRDY.
- `readyfordata` in 1: SPI master TRDY.

## Operation
- Register addresses used: 0 = rx data, 1 = tx data, 3 = control, 5 = slave-enable.
- Bus access:
  - Every access holds `spi_select`=1 and either `write_n`=0 or `read_n`=0 for exactly 2 cycles, with `mem_addr` and `data_from_cpu` stable.
  - The access is followed by at least 1 idle cycle (`spi_select`=0, both strobes high).
  - Read data is `data_to_cpu[7:0]`, sampled at the edge that ends the 2nd read cycle.
- States:
  - IDLE: on `cmd_valid`, latch address and length, reset the byte counter, go to SEL.
  - SEL: write addr 5 = 16'h0001, then go to SSO_ON.
  - SSO_ON: write addr 3 = 16'h0400 (SSO set, all IRQ enables 0), then go to TX_WAIT.
  - TX_WAIT: wait for `readyfordata`=1, then go to TX_WR.
  - TX_WR: write addr 1 with the current tx byte, then go to RX_WAIT.
  - RX_WAIT: wait for `dataavailable`=1, then go to RX_RD.
  - RX_RD: read addr 0. Header or dummy byte: discard it and go to NEXT. Data byte: go to OUT.
  - OUT: `rd_valid`=1; leave when `rd_ready`=1 (one-cycle transfer), then go to NEXT.
  - NEXT: if bytes remain, go to TX_WAIT; otherwise go to SSO_OFF.
  - SSO_OFF: write addr 3 = 16'h0000, then go to FIN.
  - FIN: pulse `done`, go to IDLE.
- Byte sequence:
  - Header: opcode, `addr[23:16]`, `addr[15:8]`, `addr[7:0]`.
  - Then `cmd_len` bytes of 8'h00; these are the data bytes.
- Exactly one byte is in flight at a time. Every received byte is read, so the master never sets ROE or TOE.
- Byte counter is 17 bits: header + optional dummy + `cmd_len`. There is no wrap; `cmd_len` = 16'hFFFF is legal.
- Stream back-pressure stalls the sequencer in OUT. SS stays asserted and SCLK stays idle while stalled.
- `cmd_valid` outside IDLE is ignored; the command is not queued.

## Timing
- Reset values: `cmd_ready`=1, `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0, `spi_select`=0, `write_n`=1, `read_n`=1, `mem_addr`=0, `data_from_cpu`=0.
- Reset mid-transaction: return to IDLE immediately. The SPI master shares `reset`, so SSO and SS also clear.
- Latency:
  - `cmd_valid` accepted to first `spi_select` high: 1 cycle.
  - Bus overhead per byte: 2 cycles (write access) + 1 idle cycle + 2 cycles (read access) + 1 idle cycle, plus the serial time of the master (18 states × 3 clk = 54 clk).
- `rd_valid` rises in the cycle after the RX_RD sample edge. `rd_valid` is held with `rd_data` stable until `rd_ready` is high.
- `done` rises 1 cycle after the SSO_OFF access ends. `busy` falls and `cmd_ready` rises in the same cycle.
- `cmd_valid` high in the same cycle as `done`: not accepted. It is accepted in the next cycle, when the sequencer is in IDLE.

## Configuration
- `FLASH_SPI_FAST_READ_EN` defined:
  - Opcode is `OPCODE_FAST`.
  - One extra 8'h00 dummy byte follows the address; its received byte is discarded.
  - Header is 5 bytes.
- Not defined: opcode is `OPCODE_READ`, header is 4 bytes, and no dummy logic is built.

## Structure
- Package `flash_spi_pkg` holds:
  - State enum.
  - Register address constants: `SPI_ADDR_RXDATA`, `SPI_ADDR_TXDATA`, `SPI_ADDR_CONTROL`, `SPI_ADDR_SSEL`.
  - Constant `SPI_CTRL_SSO` = 16'h0400.
  - Header-length constant, which depends on the macro.
- Sub-module `flash_spi_bus_acc`:
  - Performs one 2-cycle read or write access plus the trailing idle cycle.
  - Returns an `acc_done` pulse and the captured byte.
  - The sequencer FSM issues requests to it.

## Test plan
- Read addr 24'h012345, len 2, with a master model echoing MISO 8'hA5, 8'h5A after the header → tx bytes 03, 01, 23, 45, 00, 00; `rd_data` A5 then 5A; one `done` pulse; SS low for the whole transaction.
- `cmd_len`=0 → 4 header bytes only; `rd_valid` never asserted; control writes 0400 then 0000.
- `rd_ready` held low for 100 cycles on byte 1 of len 3 → `rd_data` stable; no addr-1 write until the handshake completes; master ROE/TOE stay 0.
- Access checker on every bus access → each access is exactly 2 cycles with stable `mem_addr`, followed by at least 1 idle cycle; no addr-1 write while `readyfordata`=0.
- `reset` asserted mid-way through data byte 2 → all outputs at reset values in the same cycle; the next command completes normally.
- With `FLASH_SPI_FAST_READ_EN`, addr 24'h000010, len 1 → tx bytes 0B, 00, 00, 10, 00, 00; exactly 1 byte delivered.

Source files
------------

// File: rtl/flash_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flash_spi_pkg
// Brief    : Shared states and SPI-master register map for the flash read
//            sequencer. FLASH_SPI_FAST_READ_EN selects the 5-byte header.
// Revision : 1.0 - initial release
// ============================================================================
package flash_spi_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_SEL     = 4'd1,
      S_SSO_ON  = 4'd2,
      S_TX_WAIT = 4'd3,
      S_TX_WR   = 4'd4,
      S_RX_WAIT = 4'd5,
      S_RX_RD   = 4'd6,
      S_OUT     = 4'd7,
      S_NEXT    = 4'd8,
      S_SSO_OFF = 4'd9,
      S_FIN     = 4'd10
   } seq_state_e;

   localparam logic [2:0]  SPI_ADDR_RXDATA  = 3'd0;
   localparam logic [2:0]  SPI_ADDR_TXDATA  = 3'd1;
   localparam logic [2:0]  SPI_ADDR_CONTROL = 3'd3;
   localparam logic [2:0]  SPI_ADDR_SSEL    = 3'd5;

   localparam logic [15:0] SPI_CTRL_SSO     = 16'h0400;
   localparam logic [15:0] SPI_SSEL_SLAVE0  = 16'h0001;

`ifdef FLASH_SPI_FAST_READ_EN
   localparam logic [16:0] HDR_LEN = 17'd5;
`else
   localparam logic [16:0] HDR_LEN = 17'd4;
`endif

endpackage
`default_nettype wire

// File: rtl/flash_spi_bus_acc.sv
`default_nettype none
// ============================================================================
// Module   : flash_spi_bus_acc
// Brief    : One 2-cycle SPI-master register read or write, then one idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
module flash_spi_bus_acc (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic        i_wr,
   input  logic [2:0]  i_addr,
   input  logic [15:0] i_wdata,
   input  logic [7:0]  i_rdata,
   output logic        o_acc_done,
   output logic [7:0]  o_rbyte,
   output logic        o_spi_select,
   output logic [2:0]  o_mem_addr,
   output logic        o_write_n,
   output logic        o_read_n,
   output logic [15:0] o_data_from_cpu
);

   localparam logic [1:0] PH_1   = 2'd0;
   localparam logic [1:0] PH_2   = 2'd1;
   localparam logic [1:0] PH_GAP = 2'd2;

   logic [1:0] r_ph;
   logic [7:0] r_rbyte;
   logic       w_active;

   // The requester holds its command steady until o_acc_done, so the bus
   // signals are decoded straight from it and stay stable for both cycles.
   assign w_active        = i_req && (r_ph != PH_GAP);
   assign o_spi_select    = w_active;
   assign o_mem_addr      = w_active ? i_addr : 3'd0;
   assign o_write_n       = !(w_active && i_wr);
   assign o_read_n        = !(w_active && !i_wr);
   assign o_data_from_cpu = (w_active && i_wr) ? i_wdata : 16'h0000;
   assign o_acc_done      = i_req && (r_ph == PH_2);
   assign o_rbyte         = r_rbyte;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ph    <= PH_1;
         r_rbyte <= 8'h00;
      end else begin
         case (r_ph)
            PH_1:    if (i_req) r_ph <= PH_2;
            PH_2: begin
               r_ph <= PH_GAP;
               if (!i_wr) r_rbyte <= i_rdata;
            end
            PH_GAP:  r_ph <= PH_1;
            default: r_ph <= PH_1;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/flash_spi_rd_seq.sv
`default_nettype none
// ============================================================================
// Module   : flash_spi_rd_seq
// Brief    : Flash READ sequencer driving an 8-bit SPI master register port.
//            FLASH_SPI_FAST_READ_EN selects fast read with one dummy byte.
// Revision : 1.0 - initial release
// ============================================================================
module flash_spi_rd_seq
   import flash_spi_pkg::*;
#(
   parameter logic [7:0] OPCODE_READ = 8'h03,
   parameter logic [7:0] OPCODE_FAST = 8'h0B
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [23:0] cmd_addr,
   input  logic [15:0] cmd_len,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        busy,
   output logic        done,
   output logic        spi_select,
   output logic [2:0]  mem_addr,
   output logic        write_n,
   output logic        read_n,
   output logic [15:0] data_from_cpu,
   input  logic [15:0] data_to_cpu,
   input  logic        dataavailable,
   input  logic        readyfordata
);

`ifdef FLASH_SPI_FAST_READ_EN
   localparam logic [7:0] c_opcode = OPCODE_FAST;
`else
   localparam logic [7:0] c_opcode = OPCODE_READ;
`endif

   seq_state_e  r_state, w_next;
   logic [23:0] r_addr;
   logic [16:0] r_total;
   logic [16:0] r_cnt;
   logic [7:0]  w_tx_byte;
   logic        w_is_data;
   logic        w_req, w_req_wr, w_acc_done;
   logic [2:0]  w_req_addr;
   logic [15:0] w_req_wdata;
   logic [15:0] w_unused_bits;

   assign w_unused_bits = {data_to_cpu[15:8], OPCODE_READ ^ OPCODE_FAST};
   assign w_is_data     = (r_cnt >= HDR_LEN);

   always_comb begin
      w_tx_byte = 8'h00;
      case (r_cnt)
         17'd0:   w_tx_byte = c_opcode;
         17'd1:   w_tx_byte = r_addr[23:16];
         17'd2:   w_tx_byte = r_addr[15:8];
         17'd3:   w_tx_byte = r_addr[7:0];
         default: w_tx_byte = 8'h00;
      endcase
   end

   // Bus requests depend on state only, keeping acc_done out of this path.
   always_comb begin
      w_req       = 1'b0;
      w_req_wr    = 1'b0;
      w_req_addr  = 3'd0;
      w_req_wdata = 16'h0000;
      case (r_state)
         S_SEL: begin
            w_req = 1'b1; w_req_wr = 1'b1;
            w_req_addr = SPI_ADDR_SSEL; w_req_wdata = SPI_SSEL_SLAVE0;
         end
         S_SSO_ON: begin
            w_req = 1'b1; w_req_wr = 1'b1;
            w_req_addr = SPI_ADDR_CONTROL; w_req_wdata = SPI_CTRL_SSO;
         end
         S_TX_WR: begin
            w_req = 1'b1; w_req_wr = 1'b1;
            w_req_addr = SPI_ADDR_TXDATA; w_req_wdata = {8'h00, w_tx_byte};
         end
         S_RX_RD: begin
            w_req = 1'b1; w_req_addr = SPI_ADDR_RXDATA;
         end
         S_SSO_OFF: begin
            w_req = 1'b1; w_req_wr = 1'b1;
            w_req_addr = SPI_ADDR_CONTROL; w_req_wdata = 16'h0000;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (cmd_valid) w_next = S_SEL;
         S_SEL:     if (w_acc_done) w_next = S_SSO_ON;
         S_SSO_ON:  if (w_acc_done) w_next = S_TX_WAIT;
         S_TX_WAIT: if (readyfordata) w_next = S_TX_WR;
         S_TX_WR:   if (w_acc_done) w_next = S_RX_WAIT;
         S_RX_WAIT: if (dataavailable) w_next = S_RX_RD;
         S_RX_RD:   if (w_acc_done) w_next = w_is_data ? S_OUT : S_NEXT;
         S_OUT:     if (rd_ready) w_next = S_NEXT;
         S_NEXT:    w_next = ((r_cnt + 17'd1) < r_total) ? S_TX_WAIT : S_SSO_OFF;
         S_SSO_OFF: if (w_acc_done) w_next = S_FIN;
         S_FIN:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_addr  <= 24'h000000;
         r_total <= 17'd0;
         r_cnt   <= 17'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && cmd_valid) begin
            r_addr  <= cmd_addr;
            r_total <= HDR_LEN + {1'b0, cmd_len};
            r_cnt   <= 17'd0;
         end else if (r_state == S_NEXT) begin
            r_cnt <= r_cnt + 17'd1;
         end
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_FIN);
   assign rd_valid  = (r_state == S_OUT);

   flash_spi_bus_acc u_bus_acc (
      .clk             (clk),
      .reset           (reset),
      .i_req           (w_req),
      .i_wr            (w_req_wr),
      .i_addr          (w_req_addr),
      .i_wdata         (w_req_wdata),
      .i_rdata         (data_to_cpu[7:0]),
      .o_acc_done      (w_acc_done),
      .o_rbyte         (rd_data),
      .o_spi_select    (spi_select),
      .o_mem_addr      (mem_addr),
      .o_write_n       (write_n),
      .o_read_n        (read_n),
      .o_data_from_cpu (data_from_cpu)
   );

endmodule
`default_nettype wire

// File: tb/tb_flash_spi_rd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_spi_rd_seq
// Brief    : Directed bench for flash_spi_rd_seq with an SPI master model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_spi_rd_seq;

`ifdef FLASH_SPI_FAST_READ_EN
   localparam int         HDR = 5;
   localparam logic [7:0] OPC = 8'h0B;
`else
   localparam int         HDR = 4;
   localparam logic [7:0] OPC = 8'h03;
`endif
   localparam logic [33:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [23:0] cmd_addr = 24'h0;
   logic [15:0] cmd_len = 16'h0;
   logic [7:0]  rd_data;
   logic        rd_valid, rd_ready = 1'b1, busy, done;
   logic        spi_select, write_n, read_n;
   logic [2:0]  mem_addr;
   logic [15:0] data_from_cpu, data_to_cpu;
   logic        dataavailable, readyfordata;

   // SPI master model state
   logic [7:0]  m_rx = 8'h00;
   logic        m_trdy = 1'b1, m_rrdy = 1'b0, m_roe = 1'b0, m_toe = 1'b0;
   int          m_busy = 0, m_idx = 0;
   logic [7:0]  miso_mem [0:15];

   // access monitor state
   logic        prev_act = 1'b0, prev_done = 1'b0, run_wr = 1'b0;
   int          run_len = 0, mon_err = 0, done_cnt = 0, rv_cycles = 0, ssel_cnt = 0;
   logic [2:0]  run_addr = 3'd0;
   logic [15:0] run_data = 16'h0;
   logic [7:0]  tx_log[$], rd_log[$], exp_tx[$], exp_rd[$];
   logic [15:0] ctrl_log[$];

   int n_checks = 0, n_fail = 0;

   assign data_to_cpu   = {8'hC3, m_rx};
   assign dataavailable = m_rrdy;
   assign readyfordata  = m_trdy;

   always #5 clk = ~clk;

   flash_spi_rd_seq dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .busy(busy), .done(done), .spi_select(spi_select),
      .mem_addr(mem_addr), .write_n(write_n), .read_n(read_n),
      .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
      .dataavailable(dataavailable), .readyfordata(readyfordata)
   );

   // Bus-access checker plus behavioural SPI master (54 clk per byte).
   always @(negedge clk) begin
      if (reset) begin
         prev_act = 1'b0; run_len = 0; prev_done = 1'b0;
         m_trdy = 1'b1; m_rrdy = 1'b0; m_busy = 0; m_idx = 0;
      end else begin
         if ((spi_select !== (!write_n || !read_n)) || (!write_n && !read_n)) mon_err++;
         if (spi_select) begin
            if (!prev_act) begin
               run_len = 1; run_addr = mem_addr; run_data = data_from_cpu; run_wr = !write_n;
               if (!write_n && mem_addr == 3'd1 && !m_trdy) mon_err++;
            end else begin
               run_len++;
               if (mem_addr !== run_addr || data_from_cpu !== run_data || run_wr !== (!write_n)) mon_err++;
            end
         end else if (prev_act) begin
            if (run_len != 2) mon_err++;
            if (run_wr) begin
               case (run_addr)
                  3'd1: begin
                     if (!m_trdy) m_toe = 1'b1;
                     tx_log.push_back(run_data[7:0]);
                     m_trdy = 1'b0; m_busy = 54;
                  end
                  3'd3: ctrl_log.push_back(run_data);
                  3'd5: begin
                     if (run_data != 16'h0001) mon_err++;
                     ssel_cnt++; m_idx = 0;
                  end
                  default: mon_err++;
               endcase
            end else begin
               if (run_addr != 3'd0) mon_err++;
               m_rrdy = 1'b0;
            end
         end
         prev_act = spi_select;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               if (m_rrdy) m_roe = 1'b1;
               m_rx = (m_idx < HDR) ? 8'hFF : miso_mem[(m_idx - HDR) % 16];
               m_idx++; m_rrdy = 1'b1; m_trdy = 1'b1;
            end
         end
         if (done) begin
            done_cnt++;
            if (prev_done) mon_err++;
         end
         prev_done = done;
         if (rd_valid) rv_cycles++;
         if (rd_valid && rd_ready) rd_log.push_back(rd_data);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   function automatic int tx_diff();
      for (int i = 0; i < exp_tx.size(); i++)
         if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) return i;
      return (tx_log.size() == exp_tx.size()) ? -1 : exp_tx.size();
   endfunction

   function automatic int rd_diff();
      for (int i = 0; i < exp_rd.size(); i++)
         if (i >= rd_log.size() || rd_log[i] !== exp_rd[i]) return i;
      return (rd_log.size() == exp_rd.size()) ? -1 : exp_rd.size();
   endfunction

   task automatic clear_logs();
      tx_log.delete(); rd_log.delete(); ctrl_log.delete(); exp_tx.delete(); exp_rd.delete();
      mon_err = 0; done_cnt = 0; rv_cycles = 0; ssel_cnt = 0; m_roe = 1'b0; m_toe = 1'b0;
   endtask

   task automatic build_exp(input logic [23:0] a, input int len);
      exp_tx.push_back(OPC);
      exp_tx.push_back(a[23:16]);
      exp_tx.push_back(a[15:8]);
      exp_tx.push_back(a[7:0]);
`ifdef FLASH_SPI_FAST_READ_EN
      exp_tx.push_back(8'h00);
`endif
      for (int i = 0; i < len; i++) exp_tx.push_back(8'h00);
   endtask

   task automatic issue_cmd(input logic [23:0] a, input logic [15:0] l, output logic sel);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
      @(posedge clk); #1;
      sel = spi_select;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int i;
      i = 0;
      while (done_cnt < target && i < 5000) begin
         @(negedge clk); i++;
      end
      n_checks++;
      if (done_cnt < target) begin
         $display("FAIL wait_done: done pulses %0d, required %0d", done_cnt, target);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cmd_ready, busy, done, rd_valid, rd_data, spi_select, write_n, read_n, mem_addr, data_from_cpu} !== RST_VEC) begin
         $display("FAIL reset_values: got %h required %h", {cmd_ready, busy, done, rd_valid, rd_data, spi_select, write_n, read_n, mem_addr, data_from_cpu}, RST_VEC);
         n_fail++;
      end
      @(posedge clk); #1; reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({cmd_ready, busy, spi_select} !== 3'b100) begin
         $display("FAIL idle_after_reset: got %b required 100", {cmd_ready, busy, spi_select});
         n_fail++;
      end
   endtask

   task automatic test_basic_read();
      logic sel;
      int   d;
      clear_logs();
      miso_mem[0] = 8'hA5; miso_mem[1] = 8'h5A;
      build_exp(24'h012345, 2);
      exp_rd.push_back(8'hA5); exp_rd.push_back(8'h5A);
      issue_cmd(24'h012345, 16'd2, sel);
      n_checks++;
      if (sel !== 1'b1) begin
         $display("FAIL basic select_latency: spi_select %b, required 1", sel); n_fail++;
      end
      wait_done(1);
      d = tx_diff();
      n_checks++;
      if (d != -1) begin
         $display("FAIL basic tx_bytes: idx %0d got %h required %h (%0d vs %0d bytes)", d,
                  (d < tx_log.size()) ? tx_log[d] : 8'h00, (d < exp_tx.size()) ? exp_tx[d] : 8'h00, tx_log.size(), exp_tx.size());
         n_fail++;
      end
      d = rd_diff();
      n_checks++;
      if (d != -1) begin
         $display("FAIL basic rd_data: idx %0d got %h required %h (%0d vs %0d bytes)", d,
                  (d < rd_log.size()) ? rd_log[d] : 8'h00, (d < exp_rd.size()) ? exp_rd[d] : 8'h00, rd_log.size(), exp_rd.size());
         n_fail++;
      end
      n_checks++;
      if (!(ctrl_log.size() == 2 && ctrl_log[0] === 16'h0400 && ctrl_log[1] === 16'h0000) || ssel_cnt != 1) begin
         $display("FAIL basic ctrl_writes: %0d ctrl writes, %0d ssel writes, required 0400,0000 and 1", ctrl_log.size(), ssel_cnt);
         n_fail++;
      end
      @(posedge clk); #1;
      n_checks++;
      if ({busy, cmd_ready, done, done_cnt} !== {3'b010, 32'sd1}) begin
         $display("FAIL basic after_done: busy/ready/done %b pulses %0d, required 010 and 1", {busy, cmd_ready, done}, done_cnt);
         n_fail++;
      end
      n_checks++;
      if (mon_err != 0 || m_roe || m_toe) begin
         $display("FAIL basic bus_protocol: %0d violations roe %b toe %b, required 0 0 0", mon_err, m_roe, m_toe);
         n_fail++;
      end
   endtask

   task automatic test_len_zero();
      logic sel;
      int   d;
      clear_logs();
      build_exp(24'hFEDCBA, 0);
      issue_cmd(24'hFEDCBA, 16'd0, sel);
      wait_done(1);
      d = tx_diff();
      n_checks++;
      if (d != -1) begin
         $display("FAIL len0 tx_bytes: idx %0d got %0d bytes required %0d bytes", d, tx_log.size(), exp_tx.size());
         n_fail++;
      end
      n_checks++;
      if (rv_cycles != 0) begin
         $display("FAIL len0 rd_valid: asserted %0d cycles, required 0", rv_cycles); n_fail++;
      end
      n_checks++;
      if (!(ctrl_log.size() == 2 && ctrl_log[0] === 16'h0400 && ctrl_log[1] === 16'h0000) || mon_err != 0) begin
         $display("FAIL len0 ctrl_writes: %0d ctrl writes, %0d violations, required 2 and 0", ctrl_log.size(), mon_err);
         n_fail++;
      end
   endtask

   task automatic test_backpressure();
      logic sel;
      int   d, i, bad, tx_before;
      logic [7:0] held;
      clear_logs();
      miso_mem[0] = 8'h11; miso_mem[1] = 8'h22; miso_mem[2] = 8'h33;
      exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
      @(posedge clk); #1; rd_ready = 1'b0;
      issue_cmd(24'h00ABCD, 16'd3, sel);
      i = 0;
      while (!rd_valid && i < 2000) begin @(negedge clk); i++; end
      held = rd_data;
      n_checks++;
      if (rd_valid !== 1'b1 || held !== 8'h11) begin
         $display("FAIL bp first_byte: rd_valid %b rd_data %h, required 1 and 11", rd_valid, held); n_fail++;
      end
      tx_before = tx_log.size();
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (rd_valid !== 1'b1 || rd_data !== held || tx_log.size() != tx_before || spi_select !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         $display("FAIL bp stall_hold: %0d bad stall cycles, required 0", bad); n_fail++;
      end
      @(posedge clk); #1; rd_ready = 1'b1;
      wait_done(1);
      d = rd_diff();
      n_checks++;
      if (d != -1) begin
         $display("FAIL bp rd_data: idx %0d got %0d bytes required %0d bytes", d, rd_log.size(), exp_rd.size());
         n_fail++;
      end
      n_checks++;
      if (m_roe || m_toe || mon_err != 0) begin
         $display("FAIL bp overrun: roe %b toe %b violations %0d, required 0 0 0", m_roe, m_toe, mon_err); n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      int i, d;
      clear_logs();
      miso_mem[0] = 8'h77;
      build_exp(24'h100200, 1);
      build_exp(24'h300400, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = 24'h100200; cmd_len = 16'd1;
      @(posedge clk); #1;
      cmd_addr = 24'h300400;
      i = 0;
      while (!done && i < 5000) begin @(negedge clk); i++; end
      n_checks++;
      if (done !== 1'b1 || cmd_ready !== 1'b0) begin
         $display("FAIL b2b done_cycle: done %b cmd_ready %b, required 1 0", done, cmd_ready); n_fail++;
      end
      @(posedge clk); #1;
      n_checks++;
      if ({cmd_ready, busy} !== 2'b10) begin
         $display("FAIL b2b idle_cycle: ready/busy %b, required 10", {cmd_ready, busy}); n_fail++;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_done(2);
      d = tx_diff();
      n_checks++;
      if (d != -1) begin
         $display("FAIL b2b tx_bytes: idx %0d got %h required %h (%0d vs %0d bytes)", d,
                  (d < tx_log.size()) ? tx_log[d] : 8'h00, (d < exp_tx.size()) ? exp_tx[d] : 8'h00, tx_log.size(), exp_tx.size());
         n_fail++;
      end
      repeat (20) @(negedge clk);
      n_checks++;
      if (done_cnt != 2 || rd_log.size() != 2 || mon_err != 0) begin
         $display("FAIL b2b counts: done %0d bytes %0d violations %0d, required 2 2 0", done_cnt, rd_log.size(), mon_err);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid();
      logic sel;
      int   i, d;
      clear_logs();
      miso_mem[0] = 8'h44; miso_mem[1] = 8'h55; miso_mem[2] = 8'h66;
      issue_cmd(24'h0F0F0F, 16'd3, sel);
      i = 0;
      while (tx_log.size() < HDR + 2 && i < 3000) begin @(negedge clk); i++; end
      repeat (10) @(negedge clk);
      @(posedge clk); #1; reset = 1'b1; #1;
      n_checks++;
      if ({cmd_ready, busy, done, rd_valid, rd_data, spi_select, write_n, read_n, mem_addr, data_from_cpu} !== RST_VEC) begin
         $display("FAIL reset_mid values: got %h required %h", {cmd_ready, busy, done, rd_valid, rd_data, spi_select, write_n, read_n, mem_addr, data_from_cpu}, RST_VEC);
         n_fail++;
      end
      repeat (3) @(negedge clk);
      clear_logs();
      @(posedge clk); #1; reset = 1'b0;
      miso_mem[0] = 8'h3C;
      build_exp(24'hABCDEF, 1);
      exp_rd.push_back(8'h3C);
      issue_cmd(24'hABCDEF, 16'd1, sel);
      wait_done(1);
      d = tx_diff();
      n_checks++;
      if (d != -1 || rd_diff() != -1) begin
         $display("FAIL reset_mid recovery: tx idx %0d, %0d rx bytes (first %h), required 1 byte 3c",
                  d, rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 8'h00);
         n_fail++;
      end
   endtask

`ifdef FLASH_SPI_FAST_READ_EN
   task automatic test_fast_read();
      logic sel;
      int   d;
      clear_logs();
      miso_mem[0] = 8'h96;
      exp_tx = '{8'h0B, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
      issue_cmd(24'h000010, 16'd1, sel);
      wait_done(1);
      d = tx_diff();
      n_checks++;
      if (d != -1 || rd_log.size() != 1) begin
         $display("FAIL fast tx_bytes: idx %0d, %0d bytes delivered, required match and 1", d, rd_log.size());
         n_fail++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_read();
      test_len_zero();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef FLASH_SPI_FAST_READ_EN
      test_fast_read();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
